bus_router_1to2: RTL and testbench



---
 rtl/bus_pkg.sv | 29 ++
 rtl/bus_watchdog.sv | 33 +++
 rtl/bus_router_1to2.sv | 153 +++++++++++++++
 tb/tb_bus_router_1to2.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared bus types and constants for the CPU data-bus bridges.
// Holds FSM encoding, default address map and request bundle.
package bus_pkg;

  localparam int BUS_W = 32;

  localparam logic [BUS_W-1:0] IO_BASE_DEF  = 32'hFFFF_0000;
  localparam logic [BUS_W-1:0] ERR_WORD_DEF = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic             we;
    logic [BUS_W-1:0] addr;
    logic [BUS_W-1:0] wdata;
  } bus_req_t;

  function automatic logic is_io(
    input logic [BUS_W-1:0] a,
    input logic [BUS_W-1:0] base
  );
    return a >= base;
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Loadable cycle counter for bus bridges.
// Flags expire once the count reaches TIMEOUT-1.
module bus_watchdog #(
  parameter int TIMEOUT = 16,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic          ld,
  input  logic [CW-1:0] din,
  output logic [CW-1:0] cnt,
  output logic          expire
);

  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= din;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = (cnt == LAST);

endmodule

// File: rtl/bus_router_1to2.sv
// 1:2 data-bus router: RAM below IO_BASE, MMIO at and above.
// Watchdog turns an unanswered request into an error completion.
module bus_router_1to2
  import bus_pkg::*;
#(
  parameter logic [31:0] IO_BASE  = IO_BASE_DEF,
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_WORD = ERR_WORD_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m_stb,
  input  logic        m_we,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  output logic        m_ack,
  output logic        m_err,
  output logic [31:0] m_rdata,
  output logic        s0_stb,
  output logic        s0_we,
  output logic [31:0] s0_addr,
  output logic [31:0] s0_wdata,
  input  logic        s0_ack,
  input  logic [31:0] s0_rdata,
  output logic        s1_stb,
  output logic        s1_we,
  output logic [31:0] s1_addr,
  output logic [31:0] s1_wdata,
  input  logic        s1_ack,
  input  logic [31:0] s1_rdata
);

  state_t      state_q, state_d;
  bus_req_t    req_q, req_d;
  logic        tgt_q, tgt_d;
  logic        s0_stb_d, s1_stb_d;
  logic        ack_d, err_d;
  logic [31:0] rdata_d;
  logic        sel_ack;
  logic [31:0] sel_rdata;
  logic        wd_clr, wd_en, wd_exp;
  logic [15:0] wd_cnt;

  bus_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CW      (16)
  ) u_wd (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (wd_clr),
    .en     (wd_en),
    .ld     (1'b0),
    .din    (16'd0),
    .cnt    (wd_cnt),
    .expire (wd_exp)
  );

  always_comb begin
    sel_ack   = 1'b0;
    sel_rdata = '0;
    unique case (1'b1)
      tgt_q: begin
        sel_ack   = s1_ack;
        sel_rdata = s1_rdata;
      end
      !tgt_q: begin
        sel_ack   = s0_ack;
        sel_rdata = s0_rdata;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    tgt_d    = tgt_q;
    s0_stb_d = s0_stb;
    s1_stb_d = s1_stb;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    rdata_d  = m_rdata;
    wd_clr   = 1'b0;
    wd_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (m_stb) begin
          req_d    = '{we: m_we, addr: m_addr, wdata: m_wdata};
          tgt_d    = is_io(m_addr, IO_BASE);
          s0_stb_d = !tgt_d;
          s1_stb_d = tgt_d;
          wd_clr   = 1'b1;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        wd_en = 1'b1;
        // ack wins over a same-cycle expiry
        if (sel_ack) begin
          rdata_d  = sel_rdata;
          s0_stb_d = 1'b0;
          s1_stb_d = 1'b0;
          ack_d    = 1'b1;
          state_d  = DONE;
        end else if (wd_exp) begin
          rdata_d  = ERR_WORD;
          s0_stb_d = 1'b0;
          s1_stb_d = 1'b0;
          ack_d    = 1'b1;
          err_d    = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        s0_stb_d = 1'b0;
        s1_stb_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= '0;
      tgt_q   <= 1'b0;
      s0_stb  <= 1'b0;
      s1_stb  <= 1'b0;
      m_ack   <= 1'b0;
      m_err   <= 1'b0;
      m_rdata <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      tgt_q   <= tgt_d;
      s0_stb  <= s0_stb_d;
      s1_stb  <= s1_stb_d;
      m_ack   <= ack_d;
      m_err   <= err_d;
      m_rdata <= rdata_d;
    end
  end

  assign s0_we    = req_q.we;
  assign s0_addr  = req_q.addr;
  assign s0_wdata = req_q.wdata;
  assign s1_we    = req_q.we;
  assign s1_addr  = req_q.addr;
  assign s1_wdata = req_q.wdata;

endmodule

// File: tb/tb_bus_router_1to2.sv
// Directed bench for bus_router_1to2 with slave models.
// Expected completions queue at request, compare at m_ack.
module tb_bus_router_1to2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m_stb = 1'b0, m_we = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic        m_ack, m_err;
  logic [31:0] m_rdata;
  logic        s0_stb, s0_we, s1_stb, s1_we;
  logic [31:0] s0_addr, s0_wdata, s1_addr, s1_wdata;
  logic        s0_ack, s1_ack;
  logic [31:0] s0_rdata = '0, s1_rdata = '0;

  logic s0_en = 1'b1, s1_en = 1'b1;
  logic s1_spam = 1'b0, s1_force = 1'b0;
  int   s0_wait = 0, s1_wait = 0;
  int   s0_cnt = 0, s1_cnt = 0;
  int   cyc = 0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];

  logic        cur_we;
  logic [31:0] cur_addr, cur_wdata;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    s0_cnt <= s0_stb ? s0_cnt + 1 : 0;
    s1_cnt <= s1_stb ? s1_cnt + 1 : 0;
  end

  assign s0_ack = s0_en && s0_stb && (s0_cnt >= s0_wait);
  assign s1_ack = (s1_en && s1_stb && (s1_cnt >= s1_wait))
                | (s1_spam && cyc[0]) | s1_force;

  bus_router_1to2 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m_stb    (m_stb),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_ack    (m_ack),
    .m_err    (m_err),
    .m_rdata  (m_rdata),
    .s0_stb   (s0_stb),
    .s0_we    (s0_we),
    .s0_addr  (s0_addr),
    .s0_wdata (s0_wdata),
    .s0_ack   (s0_ack),
    .s0_rdata (s0_rdata),
    .s1_stb   (s1_stb),
    .s1_we    (s1_we),
    .s1_addr  (s1_addr),
    .s1_wdata (s1_wdata),
    .s1_ack   (s1_ack),
    .s1_rdata (s1_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic we, input logic [31:0] a,
                       input logic [31:0] d, input exp_t e);
    m_stb     = 1'b1;
    m_we      = we;
    m_addr    = a;
    m_wdata   = d;
    cur_we    = we;
    cur_addr  = a;
    cur_wdata = d;
    sb.push_back(e);
  endtask

  task automatic wait_ack(input int lim, output int n, output int h0,
                          output int h1, output int bad);
    n = 0; h0 = 0; h1 = 0; bad = 0;
    while (n < lim) begin
      @(negedge clk);
      n++;
      if (s0_stb) begin
        h0++;
        if (s0_addr !== cur_addr || s0_wdata !== cur_wdata ||
            s0_we !== cur_we) bad++;
      end
      if (s1_stb) begin
        h1++;
        if (s1_addr !== cur_addr || s1_wdata !== cur_wdata ||
            s1_we !== cur_we) bad++;
      end
      if (m_ack) break;
    end
    if (m_ack !== 1'b1) chk("ack_wait", 32'(m_ack), 32'd1);
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_rdata"}, m_rdata, e.rdata);
      chk({tag, "_err"}, 32'(m_err), 32'(e.err));
    end
  endtask

  initial begin
    int n, h0, h1, bad;

    repeat (3) @(negedge clk);
    chk("rst_s0_stb", 32'(s0_stb), 0);
    chk("rst_s1_stb", 32'(s1_stb), 0);
    chk("rst_we", {30'd0, s0_we, s1_we}, 0);
    chk("rst_ack", {30'd0, m_ack, m_err}, 0);
    chk("rst_rdata", m_rdata, 0);
    chk("rst_s0_addr", s0_addr, 0);
    chk("rst_s1_wdata", s1_wdata, 0);
    rst_n = 1'b1;
    s0_ack_ign: begin
      s0_en = 1'b1;
      @(negedge clk);
      chk("idle_no_stb", {30'd0, s0_stb, s1_stb}, 0);
    end

    // read RAM, zero-wait
    s0_wait  = 0;
    s0_rdata = 32'h1234_5678;
    start(1'b0, 32'h0000_0040, 32'h0, '{err: 1'b0, rdata: 32'h1234_5678});
    wait_ack(40, n, h0, h1, bad);
    m_stb = 1'b0;
    chk("rd_lat", n, 2);
    chk("rd_s0hi", h0, 1);
    chk("rd_s1hi", h1, 0);
    pop_chk("rd");
    @(negedge clk);
    chk("rd_ack_1cyc", 32'(m_ack), 0);
    chk("rd_hold", m_rdata, 32'h1234_5678);

    // write IO, 3 wait states
    s1_wait  = 3;
    s1_rdata = 32'h0BAD_F00D;
    start(1'b1, 32'hFFFF_0004, 32'hA5A5_A5A5,
          '{err: 1'b0, rdata: 32'h0BAD_F00D});
    wait_ack(40, n, h0, h1, bad);
    m_stb = 1'b0;
    chk("wr_lat", n, 5);
    chk("wr_s1hi", h1, 4);
    chk("wr_s0hi", h0, 0);
    chk("wr_stable", bad, 0);
    pop_chk("wr");
    @(negedge clk);

    // boundary, back-to-back
    s0_wait  = 0;
    s1_wait  = 0;
    s0_rdata = 32'h0000_00A0;
    s1_rdata = 32'h0000_00B1;
    start(1'b0, 32'hFFFE_FFFF, 32'h0, '{err: 1'b0, rdata: 32'h0000_00A0});
    wait_ack(40, n, h0, h1, bad);
    chk("bnd0_s0hi", h0, 1);
    chk("bnd0_s1hi", h1, 0);
    pop_chk("bnd0");
    start(1'b0, 32'hFFFF_0000, 32'h0, '{err: 1'b0, rdata: 32'h0000_00B1});
    wait_ack(40, n, h0, h1, bad);
    m_stb = 1'b0;
    chk("bnd1_lat", n, 3);
    chk("bnd1_s1hi", h1, 1);
    chk("bnd1_s0hi", h0, 0);
    pop_chk("bnd1");
    @(negedge clk);

    // timeout with stray s1 acks
    s0_en   = 1'b0;
    s1_spam = 1'b1;
    start(1'b0, 32'h0000_1000, 32'h0, '{err: 1'b1, rdata: 32'hDEAD_BEEF});
    wait_ack(60, n, h0, h1, bad);
    m_stb   = 1'b0;
    s1_spam = 1'b0;
    chk("to_lat", n, 17);
    chk("to_s0hi", h0, 16);
    chk("to_s1hi", h1, 0);
    pop_chk("to");
    @(negedge clk);
    chk("to_err_clr", {30'd0, m_ack, m_err}, 0);

    // ack on the last watchdog cycle
    s0_en    = 1'b1;
    s0_wait  = 15;
    s0_rdata = 32'hCAFE_0001;
    start(1'b0, 32'h0000_2000, 32'h0, '{err: 1'b0, rdata: 32'hCAFE_0001});
    wait_ack(60, n, h0, h1, bad);
    m_stb = 1'b0;
    chk("col_lat", n, 17);
    chk("col_s0hi", h0, 16);
    pop_chk("col");
    @(negedge clk);

    // reset mid-BUSY
    s1_en = 1'b0;
    start(1'b0, 32'hFFFF_0100, 32'h0, '{err: 1'b0, rdata: 32'h0});
    repeat (3) @(negedge clk);
    chk("rm_s1_busy", 32'(s1_stb), 1);
    rst_n = 1'b0;
    m_stb = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("rm_stb", {30'd0, s0_stb, s1_stb}, 0);
    chk("rm_ack", 32'(m_ack), 0);
    chk("rm_rdata", m_rdata, 0);
    rst_n    = 1'b1;
    s1_force = 1'b1;
    h1 = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (m_ack || s1_stb) h1++;
    end
    s1_force = 1'b0;
    chk("rm_late_ack", h1, 0);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
